// File: rtl/coeff_mac_stage.sv
// coeff_mac_stage: serial signed dot-product stage.
// A start pulse snapshots the coefficient array. CGES samples then arrive over a
// valid/ready stream, with one multiply-accumulate per accepted sample. The final
// sum is held on a valid/ready result port until downstream takes it.
module coeff_mac_stage #(
  parameter int BITS = 32,
  parameter int CGES = 49,
  parameter int MAX  = $clog2(CGES) + BITS,
  parameter int ACC  = MAX + BITS + $clog2(CGES)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [CGES-1:0][MAX-1:0]    coeff,
  input  logic                        abort,
  input  logic                        data_valid,
  input  logic [BITS-1:0]             data_in,
  output logic                        data_ready,
  output logic signed [ACC-1:0]       result,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        busy
);

  localparam int IW = $clog2(CGES);
  localparam int PW = MAX + BITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(CGES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic signed [ACC-1:0] acc;
  logic [MAX-1:0]        coeff_q [CGES];
  logic signed [PW-1:0]  prod;
  logic signed [ACC-1:0] sum;
  logic                  xfer;

  // The handshake outputs are decoded from the state register alone, so they
  // never depend combinationally on any input.
  assign data_ready   = (state == RUN);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign xfer         = data_valid & data_ready;

  // Full-precision signed product of the current coefficient and sample,
  // sign-extended into the accumulator width. ACC covers the worst case, so
  // there is no saturation.
  // NOTE: every signal written here is assigned on every pass, which prevents a
  // latch from being inferred.
  always_comb begin
    prod = PW'($signed(coeff_q[idx])) * PW'($signed(data_in));
    sum  = acc + ACC'(prod);
  end

  // Frame control: snapshot on start, accumulate on transfer, hold until handoff.
  // Abort outranks every other event except reset.
  // NOTE: all state is updated with non-blocking assignments so that every
  // right-hand side sees values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      acc    <= '0;
      result <= '0;
      // NOTE: the coefficient shadow array is reset on purpose, so a frame
      // can never read stale coefficients from before reset.
      for (int i = 0; i < CGES; i++) coeff_q[i] <= '0;
    end else if (abort) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < CGES; i++) coeff_q[i] <= coeff[i];
            acc   <= '0;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            acc <= sum;
            if (idx == LAST_IDX) begin
              result <= sum;
              idx    <= '0;
              state  <= DONE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        DONE: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
